// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, frame constants and baud helper.
// Used by both the stimulus transmitter and the pattern-detector receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign wr_en = push_i && !full_o;
    assign rd_en = pop_i && !empty_o;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; flushing the pointers and count is enough to make it empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_stim.sv
// 8N1 UART transmitter fed by a small byte FIFO; drives the receiver's rx line.
// tx is registered from next-state so it changes on the same edge as the FSM.
module uart_tx_stim
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         tx,
    output logic                         busy,
    output logic                         frame_sent,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W = $clog2(CPB * STOP_BITS);
    localparam int IDX_W = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;

    logic                 push, pop;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full, fifo_empty;
    logic                 bit_done, stop_done;

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bit_done  = (cnt_q == CNT_W'(CPB - 1));
    assign stop_done = (cnt_q == CNT_W'(CPB * STOP_BITS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = STOP;
                    else                                idx_d   = idx_q + IDX_W'(1);
                end
            end
            STOP: begin
                if (stop_done) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_sent = (state_q == STOP) && stop_done;

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed bench for uart_tx_stim: reset, single byte, back-to-back, backpressure
// and mid-frame reset, each frame checked cycle by cycle against its 8N1 pattern.
module tb_uart_tx_stim;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 4;
    localparam int BOUND = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       frame_sent;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fs_total = 0;

    logic track = 1'b0;
    int   max_cnt = 0;
    int   ready_bad = 0;
    int   full_seen = 0;

    uart_tx_stim #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD_RATE   (100_000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_sent (frame_sent),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_sent === 1'b1) fs_total++;
    end

    // FIFO occupancy / ready tracker, cleared whenever tracking is off.
    always @(negedge clk) begin
        if (!track) begin
            max_cnt   = 0;
            ready_bad = 0;
            full_seen = 0;
        end else begin
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (tx_ready !== (int'(fifo_count) != DEPTH)) ready_bad++;
            if (tx_ready === 1'b0) full_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers one byte and returns #1 after the edge that accepted it.
    task automatic push(input logic [7:0] b, output int acc);
        logic rdy;
        int   n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        do begin
            rdy = tx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < BOUND);
        acc = cyc;
        if (!rdy) check("push_timeout", 32'(n), 32'(BOUND + 1));
    endtask

    task automatic wait_tx_low(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 32'(tx), 32'(0));
    endtask

    // Called at the negedge of frame cycle 0; returns at the negedge of cycle FRAME-1.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] frame;
        logic [7:0] got;
        int bad, fs_n, fs_at, idle_n, bit_i;
        frame  = {1'b1, b, 1'b0};
        got    = 8'h00;
        bad    = 0;
        fs_n   = 0;
        fs_at  = -1;
        idle_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            bit_i = i / CPB;
            if (tx !== frame[bit_i]) bad++;
            if (frame_sent === 1'b1) begin
                fs_n++;
                fs_at = i;
            end
            if (busy !== 1'b1) idle_n++;
            if (i % CPB == CPB / 2 && bit_i >= 1 && bit_i <= 8) got[bit_i-1] = tx;
        end
        check({tag, "_line"}, 32'(bad), 32'(0));
        check({tag, "_byte"}, 32'(got), 32'(b));
        check({tag, "_fs_n"}, 32'(fs_n), 32'(1));
        check({tag, "_fs_at"}, 32'(fs_at), 32'(FRAME - 1));
        check({tag, "_busy"}, 32'(idle_n), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int acc;
        int acc_bp[6];
        logic [7:0] bp_bytes[6];
        logic [7:0] b2b_bytes[4];
        logic [7:0] rm_bytes[3];
        bp_bytes  = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        b2b_bytes = '{8'h66, 8'hAC, 8'h66, 8'hE6};
        rm_bytes  = '{8'hF0, 8'h3C, 8'h5A};

        // Reset held for three cycles with tx_valid low.
        rst = 1'b1;
        @(posedge clk);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 ||
                fifo_count !== 3'd0 || frame_sent !== 1'b0) bad++;
        end
        check("rst_hold", 32'(bad), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // tx_data wiggling without tx_valid must be ignored.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tx_data = 8'(i * 37 + 1);
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        check("idle_ignore", 32'(bad), 32'(0));
        check("idle_ready", 32'(tx_ready), 32'(1));

        // Single byte: accepting edge writes, the next edge pops and drives tx low.
        push(8'h66, acc);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        @(negedge clk);
        check("t1_wr_tx", 32'(tx), 32'(1));
        check("t1_wr_cnt", 32'(fifo_count), 32'(1));
        @(negedge clk);
        check("t1_pop_cnt", 32'(fifo_count), 32'(0));
        check_frame(8'h66, "t1");
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'(0));
        check("t1_tx_idle", 32'(tx), 32'(1));

        // Back-to-back: four bytes on consecutive cycles, contiguous frames.
        track = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) push(b2b_bytes[i], acc);
                tx_valid = 1'b0;
            end
            begin
                wait_tx_low("t2");
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk);
                    check_frame(b2b_bytes[i], $sformatf("t2_f%0d", i));
                end
            end
        join
        @(negedge clk);
        check("t2_busy_fall", 32'(busy), 32'(0));
        check("t2_peak", 32'(max_cnt), 32'(3));
        check("t2_never_full", 32'(full_seen), 32'(0));
        check("t2_ready_rule", 32'(ready_bad), 32'(0));
        track = 1'b0;
        repeat (5) @(negedge clk);

        // Backpressure: six bytes with tx_valid held high.
        track = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) push(bp_bytes[i], acc_bp[i]);
                tx_valid = 1'b0;
            end
            begin
                wait_tx_low("t3");
                for (int i = 0; i < 6; i++) begin
                    if (i > 0) @(negedge clk);
                    check_frame(bp_bytes[i], $sformatf("t3_f%0d", i));
                end
            end
        join
        @(negedge clk);
        check("t3_busy_fall", 32'(busy), 32'(0));
        check("t3_acc5_delay", 32'(acc_bp[4] - acc_bp[0]), 32'(4));
        // First byte popped one edge after acceptance; its STOP->START pop is FRAME later.
        check("t3_acc6_delay", 32'(acc_bp[5] - acc_bp[0]), 32'(FRAME + 2));
        check("t3_peak", 32'(max_cnt), 32'(DEPTH));
        check("t3_full_seen", 32'(full_seen != 0), 32'(1));
        check("t3_ready_rule", 32'(ready_bad), 32'(0));
        track = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during DATA bit 3 of the first of three queued bytes.
        fork
            begin
                for (int i = 0; i < 3; i++) push(rm_bytes[i], acc);
                tx_valid = 1'b0;
            end
            wait_tx_low("t4");
        join
        repeat (CPB * 4 + 6) @(negedge clk);
        check("t4_bit3", 32'(tx), 32'(rm_bytes[0][3]));
        check("t4_queued", 32'(fifo_count), 32'(2));
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_tx", 32'(tx), 32'(1));
        check("t4_rst_cnt", 32'(fifo_count), 32'(0));
        check("t4_rst_busy", 32'(busy), 32'(0));
        check("t4_rst_ready", 32'(tx_ready), 32'(1));
        rst = 1'b0;
        bad = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        check("t4_quiet", 32'(bad), 32'(0));

        push(8'h55, acc);
        tx_valid = 1'b0;
        @(negedge clk);
        check("t4_wr_tx", 32'(tx), 32'(1));
        @(negedge clk);
        check_frame(8'h55, "t4_new");
        @(negedge clk);
        check("t4_busy_fall", 32'(busy), 32'(0));

        // 1 + 4 + 6 + 1 complete frames; the abandoned one never reaches its stop bit.
        check("fs_total", 32'(fs_total), 32'(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_stim.md
Name: uart_tx_stim

Overview:
- UART transmitter that sits directly upstream of the pattern-detector receive path; its serial output drives the receiver's rx line.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte as 8N1, LSB first: 1 start + 8 data + 1 stop.
- Used as the synthesizable stimulus source for on-board loopback and as the reference driver in system benches.

Parameters:
- CLK_FREQ_HZ, 1_600_000, system clock frequency in Hz.
- BAUD_RATE, 100_000, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (16 at defaults), integer and >= 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept; a transfer occurs when tx_valid && tx_ready at a rising edge.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  high while a frame is on the line (START/DATA/STOP).
- frame_sent  output  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes waiting in the FIFO (excludes the byte being shifted).

Behaviour:
- Reset values: tx=1, busy=0, frame_sent=0, fifo_count=0, tx_ready=1, state=IDLE, FIFO flushed, counters 0.
- tx_ready = (fifo_count != FIFO_DEPTH), derived from registered count only.
- Push when full is impossible because tx_ready=0. No combinational path from tx_valid to tx_ready.
- FSM states are IDLE, START, DATA, STOP:
  - IDLE, FIFO non-empty: pop head into shift register, go to START; tx=0 from the next edge. If a push lands while the FIFO is empty, tx falls 2 edges after the accepting edge (1 edge to write, 1 to pop).
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[idx] for CLKS_PER_BIT cycles each, idx 0..7; after idx 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, pulse frame_sent. If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles (160 at defaults). Back-to-back frames are contiguous.
- Baud counter counts 0..CLKS_PER_BIT-1, reloads at 0 on every state change, and wraps without drift.
- Simultaneous push and pop in the same cycle: count unchanged, both take effect. Pop when empty never occurs.
- FIFO pointers wrap modulo FIFO_DEPTH.
- busy=1 in START/DATA/STOP, including the back-to-back transition cycle.
- Reset mid-frame: at the next edge tx=1, state=IDLE, FIFO emptied, and the partial frame is abandoned. A downstream receiver may flag a framing error; this is accepted.
- tx_data is sampled only on an accepted transfer; changes to tx_data while tx_valid=0 are ignored.

Decomposition:
- Shared package uart_pkg holds:
  - a state enum (IDLE, START, DATA, STOP);
  - the function clks_per_bit(clk_hz, baud);
  - the constants DATA_BITS=8 and STOP_BITS=1.
- The receive side uses the same package.
- One sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty/count).
- Serialiser FSM and baud counter stay in uart_tx_stim.

Test Plan:
- Reset: hold rst 3 cycles, tx_valid=0 -> tx=1, busy=0, tx_ready=1, fifo_count=0 throughout, and no edge on tx.
- Single byte 0x66 -> tx low 2 cycles after the accepting edge. Line sequence 0,0,1,1,0,0,1,1,0,1, each exactly 16 cycles; frame_sent pulses once at cycle 160 of the frame; busy then falls.
- Back-to-back 0x66, 0xAC, 0x66, 0xE6 pushed on consecutive cycles -> fifo_count peaks at 3, tx_ready stays 1, 640 contiguous line cycles, 4 frame_sent pulses 160 cycles apart, tx never idles between frames.
- Backpressure: push 6 bytes with tx_valid held high -> 1 byte in flight + 4 in FIFO. tx_ready=0 while fifo_count=4, the 6th byte waits and is accepted on the cycle after the first STOP->START pop; all 6 bytes appear on the line in order.
- Reset mid-frame: assert rst during DATA bit 3 of the first of 3 queued bytes -> tx=1 next edge, fifo_count=0, nothing further transmitted. A new 0x55 then transmits correctly.
- Loopback into the pattern-detector receiver (CLK_FREQ_HZ=1_600_000, BAUD_RATE=100_000, receiver rst_n = ~rst): send 0x66 -> receiver frame_done asserts, framing_error=0, shift_window=0x66, match asserts; send 0xAC -> no match.
